// File: rtl/twiddle_mul.sv
// rtl/twiddle_mul.sv - pipelined complex multiply by twiddle factor with conjugate, round and saturate
module twiddle_mul #(
  parameter int DW    = 28,
  parameter int WW    = 16,
  parameter int SHIFT = 14,
  parameter int OW    = 28,
  parameter int TAGW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DW-1:0]     data,
  input  logic [2*WW-1:0]     w,
  input  logic                ifft,
  input  logic [TAGW-1:0]     tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*OW-1:0]     ans,
  output logic [TAGW-1:0]     tag_out,
  output logic                ovf
);

  // Conjugated imaginary part needs one extra bit so -(-2^(DW-1)) is exact.
  localparam int XW = DW + 1;
  // Pre-add widths: data sum (DW+1 operands) and twiddle sums/differences.
  localparam int AW = DW + 2;
  localparam int BW = WW + 1;
  // Product/accumulate width with headroom; every intermediate value is exact.
  localparam int PW = DW + WW + 4;

  localparam logic signed [PW-1:0] RND  = PW'((64'sd1 <<< SHIFT) >>> 1);
  localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] MINV = PW'(-(64'sd1 <<< (OW - 1)));

  logic                  w_stall;
  logic                  w_en;
  logic signed [DW-1:0]  w_dr;
  logic signed [DW-1:0]  w_di;
  logic signed [XW-1:0]  w_di_c;
  logic signed [WW-1:0]  w_wr;
  logic signed [WW-1:0]  w_wi;

  // Stage 1: conjugate/register
  logic                  r1_v;
  logic signed [DW-1:0]  r1_dr;
  logic signed [XW-1:0]  r1_di;
  logic signed [WW-1:0]  r1_wr;
  logic signed [WW-1:0]  r1_wi;
  logic [TAGW-1:0]       r1_tag;

  // Stage 2: pre-add for the three-multiplier form
  logic                  r2_v;
  logic signed [AW-1:0]  r2_sa;
  logic signed [BW-1:0]  r2_sb;
  logic signed [BW-1:0]  r2_sc;
  logic signed [DW-1:0]  r2_dr;
  logic signed [XW-1:0]  r2_di;
  logic signed [WW-1:0]  r2_wr;
  logic [TAGW-1:0]       r2_tag;

  // Stage 3: partial products
  logic                  r3_v;
  logic signed [PW-1:0]  r3_k1;
  logic signed [PW-1:0]  r3_k2;
  logic signed [PW-1:0]  r3_k3;
  logic [TAGW-1:0]       r3_tag;

  // Stage 4: final sum, round, saturate
  logic signed [PW-1:0]  w_pre;
  logic signed [PW-1:0]  w_pim;
  logic signed [PW-1:0]  w_rre;
  logic signed [PW-1:0]  w_rim;
  logic [OW-1:0]         w_qre;
  logic [OW-1:0]         w_qim;
  logic                  w_sat_re;
  logic                  w_sat_im;

  logic                  r_out_valid;
  logic [2*OW-1:0]       r_ans;
  logic [TAGW-1:0]       r_tag_out;
  logic                  r_ovf;

  // A held output blocks every stage, so the whole pipe advances together.
  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  assign w_dr   = data[2*DW-1:DW];
  assign w_di   = data[DW-1:0];
  assign w_wr   = w[2*WW-1:WW];
  assign w_wi   = w[WW-1:0];
  assign w_di_c = ifft ? -XW'(w_di) : XW'(w_di);

  // Stage 1: capture the sample with the imaginary part conjugated on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_dr  <= '0;
      r1_di  <= '0;
      r1_wr  <= '0;
      r1_wi  <= '0;
      r1_tag <= '0;
    end else if (w_en) begin
      r1_v   <= in_valid;
      r1_dr  <= w_dr;
      r1_di  <= w_di_c;
      r1_wr  <= w_wr;
      r1_wi  <= w_wi;
      r1_tag <= tag_in;
    end
  end

  // Stage 2: pre-adds sa=dr+di, sb=wi-wr, sc=wr+wi
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_sa  <= '0;
      r2_sb  <= '0;
      r2_sc  <= '0;
      r2_dr  <= '0;
      r2_di  <= '0;
      r2_wr  <= '0;
      r2_tag <= '0;
    end else if (w_en) begin
      r2_v   <= r1_v;
      r2_sa  <= AW'(r1_dr) + AW'(r1_di);
      r2_sb  <= BW'(r1_wi) - BW'(r1_wr);
      r2_sc  <= BW'(r1_wr) + BW'(r1_wi);
      r2_dr  <= r1_dr;
      r2_di  <= r1_di;
      r2_wr  <= r1_wr;
      r2_tag <= r1_tag;
    end
  end

  // Stage 3: k1=wr*(dr+di), k2=dr*(wi-wr), k3=di*(wr+wi)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v   <= 1'b0;
      r3_k1  <= '0;
      r3_k2  <= '0;
      r3_k3  <= '0;
      r3_tag <= '0;
    end else if (w_en) begin
      r3_v   <= r2_v;
      r3_k1  <= PW'(r2_wr) * PW'(r2_sa);
      r3_k2  <= PW'(r2_dr) * PW'(r2_sb);
      r3_k3  <= PW'(r2_di) * PW'(r2_sc);
      r3_tag <= r2_tag;
    end
  end

  // re = k1-k3 = dr*wr - di*wi, im = k1+k2 = dr*wi + di*wr
  assign w_pre = r3_k1 - r3_k3;
  assign w_pim = r3_k1 + r3_k2;
  assign w_rre = (w_pre + RND) >>> SHIFT;
  assign w_rim = (w_pim + RND) >>> SHIFT;

  // Clamp each rounded component to the output range and flag any clamp
  always_comb begin
    w_qre    = w_rre[OW-1:0];
    w_qim    = w_rim[OW-1:0];
    w_sat_re = 1'b0;
    w_sat_im = 1'b0;
    if (w_rre > MAXV) begin
      w_qre    = OW'(MAXV);
      w_sat_re = 1'b1;
    end else if (w_rre < MINV) begin
      w_qre    = OW'(MINV);
      w_sat_re = 1'b1;
    end
    if (w_rim > MAXV) begin
      w_qim    = OW'(MAXV);
      w_sat_im = 1'b1;
    end else if (w_rim < MINV) begin
      w_qim    = OW'(MINV);
      w_sat_im = 1'b1;
    end
  end

  // Stage 4: output register holding result, tag and saturation flag together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ans       <= '0;
      r_tag_out   <= '0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r3_v;
      r_ans       <= {w_qre, w_qim};
      r_tag_out   <= r3_tag;
      r_ovf       <= w_sat_re | w_sat_im;
    end
  end

  assign out_valid = r_out_valid;
  assign ans       = r_ans;
  assign tag_out   = r_tag_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_twiddle_mul.sv
// tb/tb_twiddle_mul.sv - scoreboard bench for twiddle_mul
module tb_twiddle_mul;
  localparam int DW    = 28;
  localparam int WW    = 16;
  localparam int SHIFT = 14;
  localparam int OW    = 28;
  localparam int TAGW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*DW-1:0]   data = '0;
  logic [2*WW-1:0]   w = '0;
  logic              ifft = 1'b0;
  logic [TAGW-1:0]   tag_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*OW-1:0]   ans;
  logic [TAGW-1:0]   tag_out;
  logic              ovf;

  twiddle_mul #(.DW(DW), .WW(WW), .SHIFT(SHIFT), .OW(OW), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .w(w), .ifft(ifft), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .ans(ans),
    .tag_out(tag_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*OW-1:0] ans;
    logic [TAGW-1:0] tag;
    logic            ovf;
    logic            chk;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;

  logic [2*OW-1:0] p_ans;
  logic [TAGW-1:0] p_tag;
  logic            p_ovf;
  bit              p_stall = 1'b0;

  function automatic logic [2*OW-1:0] pk(input longint re, input longint im);
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    a = OW'(re);
    b = OW'(im);
    return {a, b};
  endfunction

  function automatic void model(input int dr, input int di, input int wr, input int wi,
                                input logic cj, output logic [2*OW-1:0] a, output logic o);
    longint d2, pr, pi, rr, ri, mx, mn;
    d2 = cj ? -longint'(di) : longint'(di);
    pr = longint'(dr) * longint'(wr) - d2 * longint'(wi);
    pi = longint'(dr) * longint'(wi) + d2 * longint'(wr);
    rr = (pr + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    ri = (pi + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    mx = (longint'(1) <<< (OW - 1)) - 1;
    mn = -mx - 1;
    o = 1'b0;
    if (rr > mx) begin rr = mx; o = 1'b1; end
    else if (rr < mn) begin rr = mn; o = 1'b1; end
    if (ri > mx) begin ri = mx; o = 1'b1; end
    else if (ri < mn) begin ri = mn; o = 1'b1; end
    a = pk(rr, ri);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    else out_ready = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: protocol checks and scoreboard pops on output transfers
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      n_assert++;
      assert (in_ready === !(out_valid && !out_ready)) else begin
        n_fail++;
        $error("FAIL in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
      end
      if (p_stall) begin
        n_assert++;
        assert (out_valid === 1'b1 && ans === p_ans && tag_out === p_tag && ovf === p_ovf) else begin
          n_fail++;
          $error("FAIL stall_hold: got v=%b ans=%h tag=%h ovf=%b expected v=1 ans=%h tag=%h ovf=%b",
                 out_valid, ans, tag_out, ovf, p_ans, p_tag, p_ovf);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_assert++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_output: got tag=%h ans=%h expected no output", tag_out, ans);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          n_assert++;
          assert (ans === mon_e.ans) else begin
            n_fail++;
            $error("FAIL ans tag=%h: got %h expected %h", mon_e.tag, ans, mon_e.ans);
          end
          n_assert++;
          assert (tag_out === mon_e.tag) else begin
            n_fail++;
            $error("FAIL tag: got %h expected %h", tag_out, mon_e.tag);
          end
          n_assert++;
          assert (ovf === mon_e.ovf) else begin
            n_fail++;
            $error("FAIL ovf tag=%h: got %b expected %b", mon_e.tag, ovf, mon_e.ovf);
          end
          if (mon_e.chk) begin
            n_assert++;
            assert (cyc - mon_e.cyc === 3) else begin
              n_fail++;
              $error("FAIL latency tag=%h: got %0d edges expected 3 after accept", mon_e.tag, cyc - mon_e.cyc);
            end
          end
        end
      end
      p_stall = out_valid && !out_ready;
      p_ans   = ans;
      p_tag   = tag_out;
      p_ovf   = ovf;
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic send(input int dr, input int di, input int wr, input int wi, input logic cj,
                      input logic [TAGW-1:0] tg, input logic [2*OW-1:0] ea, input logic eo,
                      input logic chk);
    exp_t e;
    int   k;
    data     = {DW'(dr), DW'(di)};
    w        = {WW'(wr), WW'(wi)};
    ifft     = cj;
    tag_in   = tg;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_assert++;
    assert (in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL send_timeout tag=%h: got in_ready=%b expected 1", tg, in_ready);
    end
    e.ans = ea;
    e.tag = tg;
    e.ovf = eo;
    e.chk = chk;
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int dr, input int di, input int wr, input int wi,
                            input logic cj, input logic [TAGW-1:0] tg);
    logic [2*OW-1:0] a;
    logic            o;
    model(dr, di, wr, wi, cj, a, o);
    send(dr, di, wr, wi, cj, tg, a, o, 1'b0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  logic signed [DW-1:0] t_d0, t_d1;
  logic signed [WW-1:0] t_w0, t_w1;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    assert (out_valid === 1'b0 && ans === '0 && tag_out === '0 && ovf === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_state: got v=%b ans=%h tag=%h ovf=%b expected all 0", out_valid, ans, tag_out, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    assert (in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;

    send(1000, -2000, 16384, 0, 1'b0, 8'h01, pk(1000, -2000), 1'b0, 1'b1);
    wait_drain();
    send(1000, -2000, 0, 16384, 1'b0, 8'h02, pk(2000, 1000), 1'b0, 1'b1);
    wait_drain();
    send(1000, -2000, 0, 16384, 1'b1, 8'h03, pk(-2000, 1000), 1'b0, 1'b1);
    wait_drain();
    send(1, 0, 8192, 0, 1'b0, 8'h04, pk(1, 0), 1'b0, 1'b1);
    wait_drain();
    send(-1, 0, 8192, 0, 1'b0, 8'h05, pk(0, 0), 1'b0, 1'b1);
    wait_drain();
    send(134217727, 134217727, 16384, 16384, 1'b0, 8'h06, pk(0, 134217727), 1'b1, 1'b1);
    wait_drain();
    send(0, -134217728, 16384, 0, 1'b1, 8'h07, pk(0, 134217727), 1'b1, 1'b1);
    wait_drain();
    send(-134217728, -134217728, 16384, 16384, 1'b0, 8'h08, pk(0, -134217728), 1'b1, 1'b1);
    wait_drain();
    send(0, -134217728, 16384, 0, 1'b0, 8'h09, pk(0, -134217728), 1'b0, 1'b1);
    wait_drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_d0 = DW'($urandom);
      t_d1 = DW'($urandom);
      t_w0 = WW'($urandom);
      t_w1 = WW'($urandom);
      if (i < 8) begin
        t_d0 = t_d0 >>> 6;
        t_d1 = t_d1 >>> 6;
      end
      send_model(int'(t_d0), int'(t_d1), int'(t_w0), int'(t_w1), logic'(i % 3 == 0), TAGW'(8'h40 + i));
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send_model(100 * (i + 1), -50 * (i + 1), 16384, 0, 1'b0, TAGW'(8'h80 + i));
    end
    n_assert++;
    assert (out_valid === 1'b1) else begin
      n_fail++;
      $error("FAIL pipe_full_before_reset: got out_valid=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    assert (out_valid === 1'b0 && ans === '0 && tag_out === '0 && ovf === 1'b0) else begin
      n_fail++;
      $error("FAIL midstream_reset: got v=%b ans=%h tag=%h ovf=%b expected all 0", out_valid, ans, tag_out, ovf);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    assert (in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL ready_after_midreset: got %b expected 1", in_ready);
    end
    repeat (12) @(posedge clk);
    #1;
    n_assert++;
    assert (out_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL stale_output: got out_valid=%b expected 0", out_valid);
    end

    send(1000, -2000, 16384, 0, 1'b0, 8'hA0, pk(1000, -2000), 1'b0, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/twiddle_mul.md
TWIDDLE_MUL -- requirements
Module: twiddle_mul

Interface
REQ-001 The block SHALL take parameter DW, default 28, as the signed width of each data component (real, imaginary).
REQ-002 The block SHALL take parameter WW, default 16, as the signed width of each twiddle component.
REQ-003 The block SHALL take parameter SHIFT, default 14 (WW-2), as the right-shift applied to the exact product.
REQ-004 The block SHALL take parameter OW, default 28, as the signed width of each output component.
REQ-005 The block SHALL take parameter TAGW, default 8, as the sideband tag width.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-007 Port rst_n, input, 1 bit: the reset, asynchronous assert, active-low.
REQ-008 Port in_valid, input, 1 bit: input sample present.
REQ-009 Port in_ready, output, 1 bit: block accepts an input this cycle.
REQ-010 Port data, input, 2*DW bits: {re, im}, re in the upper DW bits.
REQ-011 Port w, input, 2*WW bits: {wr, wi}, wr in the upper WW bits.
REQ-012 Port ifft, input, 1 bit: conjugate the data (negate im) before multiplying; sampled per input.
REQ-013 Port tag_in, input, TAGW bits: sideband carried with the sample.
REQ-014 Port out_valid, output, 1 bit: result present.
REQ-015 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-016 Port ans, output, 2*OW bits: {re, im}, re in the upper OW bits.
REQ-017 Port tag_out, output, TAGW bits: tag_in of the same sample.
REQ-018 Port ovf, output, 1 bit: saturation flag for the presented result.

Function
REQ-019 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-020 The pipeline SHALL have 4 register stages: conjugate/register, pre-add, partial products, final sum/round/saturate.
REQ-021 A sample accepted in cycle t SHALL appear on ans in cycle t+4 when no stall occurs.
REQ-022 A stall SHALL exist when out_valid && !out_ready; during a stall, all stages, valid bits, tags and flags SHALL hold.
REQ-023 in_ready SHALL equal !(out_valid && !out_ready), which allows full throughput of one sample per cycle.
REQ-024 Bubbles (in_valid=0) SHALL propagate as cleared valid bits, and no sample SHALL be dropped or duplicated.
REQ-025 Conjugation SHALL compute di' = ifft ? -di : di in DW+1 bits, so that -(-2^(DW-1)) is exact.
REQ-026 The exact products SHALL be P_re = dr*wr - di'*wi and P_im = dr*wi + di'*wr, computed without internal truncation.
REQ-027 The internal structure (three-multiplier or four-multiplier form, Booth or otherwise) is free, but results SHALL be bit-exact to REQ-026.
REQ-028 Rounding SHALL be round-half-up: R = (P + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift); when SHIFT=0, R = P.
REQ-029 Saturation SHALL clamp R to the range [-2^(OW-1), 2^(OW-1)-1], separately per component.
REQ-030 ovf SHALL be 1 exactly when either component of the presented result was clamped.
REQ-031 tag_out and ovf SHALL be registered alongside ans and SHALL be valid only while out_valid=1.
REQ-032 The values of ans, tag_out and ovf while out_valid=0 are don't-care for checking but SHALL be deterministic.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately clear all stage valid bits, out_valid, ans, tag_out and ovf to 0.
REQ-034 After rst_n deasserts, in_ready SHALL be 1; a reset mid-operation SHALL discard all in-flight samples, and none SHALL emerge afterwards.
REQ-035 The datapath registers behind valid bits MAY omit reset, but the output registers SHALL reset per REQ-033.

Verification (DW=28, WW=16, SHIFT=14, OW=28)
REQ-036 Identity: data=(1000,-2000), w=(16384,0), ifft=0 -> ans=(1000,-2000) after 4 cycles, ovf=0.
REQ-037 Rotate by j: data=(1000,-2000), w=(0,16384), ifft=0 -> ans=(2000,1000); the same with ifft=1 -> ans=(-2000,1000).
REQ-038 Rounding: data=(1,0), w=(8192,0) -> ans=(1,0); data=(-1,0), w=(8192,0) -> ans=(0,0).
REQ-039 Saturation: data=(2^27-1, 2^27-1), w=(16384,16384) -> ans=(0, 2^27-1), ovf=1.
REQ-040 Backpressure: stream 16 tagged samples with random out_ready -> all 16 emerge in order with matching tags, and in_ready=0 exactly during stalls.
REQ-041 Reset mid-stream: pulse rst_n low with 3 samples in flight -> out_valid=0 immediately, and no stale output appears after release.
